// File: rtl/spi_pkg.sv
// Shared definitions for the bootloader SPI link (master side and slave width).
package spi_pkg;

   localparam int SPI_WORD_W = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD  = 3'd1,
      HIGH  = 3'd2,
      LOW   = 3'd3,
      TRAIL = 3'd4
   } spi_state_t;

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter that times each sclk phase; phase_done marks the last cycle.
module spi_phase_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   output logic phase_done_o
);

   localparam int CNT_W = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Reload on state entry, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign phase_done_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master for the bootloader link: shifts a word out MSB-first on
// mosi while capturing the slave's echo of the previous word from miso.
//
// state | meaning
// IDLE  | ready for a word, prog low, sclk low
// LEAD  | prog high, MSB on mosi, sclk low (setup before first rise)
// HIGH  | sclk high; miso sampled on the last cycle of the phase
// LOW   | sclk low; mosi already holds the next bit
// TRAIL | sclk low, prog still high, then hand rx word to host
module spi_master_tx
   import spi_pkg::*;
#(
   parameter int WORD_W  = SPI_WORD_W,
   parameter int CLK_DIV = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [WORD_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic [WORD_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   output logic              busy_o,
   output logic              prog_o,
   output logic              sclk_o,
   output logic              mosi_o,
   input  logic              miso_i
);

   localparam int BIT_W = $clog2(WORD_W + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

   spi_state_t        state_q, state_d;
   logic [WORD_W-1:0] tx_sh_q, tx_sh_d;
   logic [WORD_W-1:0] rx_sh_q, rx_sh_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              prog_q, prog_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              phase_load;
   logic              phase_done;

   spi_phase_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_timer (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_i       (phase_load),
      .phase_done_o (phase_done)
   );

   // Next-state and output decode; every transition reloads the phase timer.
   always_comb begin
      state_d    = state_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      bit_cnt_d  = bit_cnt_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      prog_d     = prog_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      phase_load = 1'b0;

      case (state_q)
         IDLE: begin
            if (tx_valid_i) begin
               state_d    = LEAD;
               tx_sh_d    = tx_data_i;
               rx_sh_d    = '0;
               bit_cnt_d  = '0;
               prog_d     = 1'b1;
               mosi_d     = tx_data_i[WORD_W-1];
               phase_load = 1'b1;
            end
         end
         LEAD: begin
            if (phase_done) begin
               state_d    = HIGH;
               sclk_d     = 1'b1;
               phase_load = 1'b1;
            end
         end
         HIGH: begin
            if (phase_done) begin
               // miso settles after the slave's own rise, so sample late in HIGH
               rx_sh_d    = {rx_sh_q[WORD_W-2:0], miso_i};
               bit_cnt_d  = bit_cnt_q + 1'b1;
               sclk_d     = 1'b0;
               phase_load = 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = TRAIL;
               end else begin
                  state_d = LOW;
                  tx_sh_d = tx_sh_q << 1;
                  mosi_d  = tx_sh_q[WORD_W-2];
               end
            end
         end
         LOW: begin
            if (phase_done) begin
               state_d    = HIGH;
               sclk_d     = 1'b1;
               phase_load = 1'b1;
            end
         end
         TRAIL: begin
            if (phase_done) begin
               state_d    = IDLE;
               prog_d     = 1'b0;
               mosi_d     = 1'b0;
               rx_data_d  = rx_sh_q;
               rx_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            prog_d  = 1'b0;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers; reset discards any partial word.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         bit_cnt_q  <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         prog_q     <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         prog_q     <= prog_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
      end
   end

   // Ready is a pure decode of the state register, so it carries no input path.
   assign tx_ready_o = (state_q == IDLE);
   assign busy_o     = (state_q != IDLE);
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign prog_o     = prog_q;
   assign sclk_o     = sclk_q;
   assign mosi_o     = mosi_q;

endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

Master end of the bootloader SPI link: accepts 16-bit program words from the host side over a valid/ready handshake and drives `prog`, `sclk`, `mosi` into the bootloader's SPI slave shift register. It shifts out MSB-first in mode 0, with `sclk` idle low, `mosi` changing while `sclk` is low, and the slave sampling on the rising edge. It also captures `miso`, the slave's echo of the previously loaded word, so the host can read back and verify each programmed word. The block sits in the programming/test harness, on the system clock, upstream of the slave.

## Interface
- `WORD_W`, 16: bits per transfer; must equal the slave shift-register width.
- `CLK_DIV`, 4: `sclk` half-period in `clk` cycles; legal range ≥1.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `tx_data` in WORD_W: word to send, captured on accept.
- `tx_valid` in 1: host offers `tx_data`.
- `tx_ready` out 1: block idle; accept occurs when `tx_valid && tx_ready`.
- `rx_data` out WORD_W: word shifted in from `miso` during the last transfer.
- `rx_valid` out 1: one-cycle pulse when `rx_data` is updated.
- `busy` out 1: equals `!tx_ready`.
- `prog` out 1: slave shift enable.
- `sclk` out 1: SPI clock to slave.
- `mosi` out 1: serial data to slave.
- `miso` in 1: serial data from slave.

## Operation
- FSM states: IDLE, LEAD, HIGH, LOW, TRAIL.
- IDLE:
  - `tx_ready`=1, `prog`=0, `sclk`=0.
  - On accept: latch `tx_data` into the tx shift register, go to LEAD.
  - `tx_data` is ignored outside accept.
- LEAD (CLK_DIV cycles): `prog`=1, `sclk`=0, `mosi`=word[WORD_W-1].
- HIGH (CLK_DIV cycles): `sclk`=1; the slave samples `mosi` on entry.
- On the last HIGH cycle:
  - Shift `miso` into the rx shift register LSB and increment the bit counter.
  - If the counter reaches WORD_W, go to TRAIL; otherwise go to LOW with `mosi` set to the next bit.
- LOW (CLK_DIV cycles): `sclk`=0, then HIGH.
- TRAIL (CLK_DIV cycles): `sclk`=0, `prog`=1.
  - Exit to IDLE.
  - On the exit edge: `rx_data` <= rx shift register, `rx_valid` pulses in the first IDLE cycle.
- Exactly WORD_W rising edges of `sclk` per accepted word. No `sclk` edge occurs while `prog`=0.
- Bit counter width: clog2(WORD_W+1). Phase counter width: clog2(CLK_DIV+1). Phase counter reloads at every state entry.
- Back-to-back transfers: an accept in the `rx_valid` cycle is legal. `prog` drops for exactly that one cycle, with `sclk` low throughout.
- `rx_data` holds its value until the next `rx_valid`.
- Reset values:
  - `tx_ready`=1, `busy`=0, `rx_valid`=0.
  - `rx_data`=0, `prog`=0, `sclk`=0, `mosi`=0.
  - State IDLE, counters 0.
- Reset mid-transfer: all outputs return to reset values on the next edge, the partial word is discarded, and no `rx_valid` is issued.

## Timing
- Accept at edge t. `prog`=1 and `mosi`=MSB from t+1.
- First `sclk` rise at t+1+CLK_DIV.
- Bit k (0-based from MSB) rises at t+1+(2k+1)·CLK_DIV.
- `rx_valid` and `tx_ready` are high at t+1+(2·WORD_W+1)·CLK_DIV; with defaults, 1+33·4 = t+133.
- `mosi` is stable ≥CLK_DIV cycles before and after each `sclk` rise.
- `miso` is sampled CLK_DIV−1 cycles after the rise, because the slave updates `miso` on the rise.
- All outputs are registered; no combinational path exists from `miso` or `tx_valid` to outputs.

## Structure
- Package `spi_pkg` holds `SPI_WORD_W`=16 (shared with the slave's width) and the `spi_state_t` enum (IDLE, LEAD, HIGH, LOW, TRAIL).
- One sub-module, `spi_phase_timer`:
  - Loadable down-counter of CLK_DIV.
  - Outputs `phase_done` on its last cycle.
  - Instantiated once.
- Shift registers, bit counter and FSM live in the top.

## Test plan
- Reset then send 0xA5C3 with CLK_DIV=4:
  - `mosi` sampled at `sclk` rises = 1010_0101_1100_0011.
  - Exactly 16 rises; `rx_valid` at accept+133.
- Loop back through a slave model:
  - Send 0x1234 then 0xBEEF.
  - The first `rx_data` is 0x0000 (reset echo); the second `rx_data` is 0x1234.
- Back-to-back: hold `tx_valid`=1 for 3 words.
  - Accepts occur on the `rx_valid` cycles.
  - `prog` is low for exactly 1 cycle between words, and `sclk` stays 0 then.
- Assert `rst` after the 7th `sclk` rise:
  - Next cycle `prog`=`sclk`=`mosi`=0 and `tx_ready`=1.
  - No `rx_valid`; the following word 0x00FF transfers cleanly.
- CLK_DIV=1, word 0xFFFF:
  - `sclk` toggles every cycle.
  - `rx_valid` at accept+34.
  - `tx_data` changed mid-transfer has no effect.
